life_counter: RTL and testbench
===============================

# life_counter

Per-player health manager for the two-player arena; it produces the `life1`/`life2` values that the life-bar renderer draws. It accepts damage events from the explosion/collision logic and applies a post-hit invulnerability window counted in video frames. It detects death and signals end-of-round with a winner code. Values are held in registers and change only on `clk`, so the renderer always sees stable values.

## Interface
Parameters:
- `LIFE_MAX`, 100: full health and the post-reset/restart value; must be ≤ 127 (7-bit output); matches the 100-px bar length
- `DAMAGE`, 25: health removed per accepted hit, 1..LIFE_MAX
- `INVULN_FRAMES`, 60: frames of invulnerability after an accepted hit, ≥ 1
- `REGEN_PERIOD`, 120: frames between regeneration steps (used only with `LIFE_REGEN_EN`), ≥ 1

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: pixel clock, same as the renderer
- `reset` in 1: asynchronous, active-high
- `frame_tick` in 1: one-cycle pulse once per video frame
- `restart` in 1: one-cycle pulse; starts a new round
- `hit1` in 1: player 1 inside an explosion this cycle (level)
- `hit2` in 1: player 2 inside an explosion this cycle (level)
- `life1` out 7: player 1 health, 0..LIFE_MAX
- `life2` out 7: player 2 health, 0..LIFE_MAX
- `invuln1` out 1: player 1 invulnerable (for sprite blinking)
- `invuln2` out 1: player 2 invulnerable
- `game_over` out 1: round ended
- `winner` out 2: 00 none, 01 P1, 10 P2, 11 draw

## Operation
- Each player has its own FSM with states ALIVE, INVULN and DEAD.
  - ALIVE and `hit`: subtract DAMAGE from life, saturating at 0. If the result is 0, go to DEAD. Otherwise load the invulnerability counter with INVULN_FRAMES and go to INVULN.
  - INVULN: `hit` is ignored. The counter decrements on each `frame_tick`. When the counter is at 1 and a `frame_tick` arrives, go to ALIVE.
  - DEAD: absorbing until `restart` or `reset`; life is held at 0.
- `invulnN` = 1 exactly while in INVULN.
- The round FSM has states PLAY and OVER.
  - PLAY → OVER when either player is DEAD.
  - `winner` is the surviving player, or 11 if both died in the same cycle.
  - In OVER, all hits and regeneration are ignored and `life` values are frozen.
- `restart` (any state): both lives = LIFE_MAX, both players ALIVE, counters cleared, `game_over` = 0, `winner` = 00, round FSM → PLAY.
- Simultaneous events:
  - `hit1` and `hit2` in the same cycle are processed independently.
  - `restart` has priority over hits.
  - A hit and `frame_tick` in the same cycle: the hit wins and the counter is loaded, not decremented.
- Arithmetic: the subtraction uses an 8-bit intermediate, so underflow saturates to 0. The invulnerability counter is $clog2(INVULN_FRAMES+1) bits wide.

## Timing
- Reset values: `life1` = `life2` = LIFE_MAX; `invuln1` = `invuln2` = 0; `game_over` = 0; `winner` = 00; both players ALIVE; round FSM in PLAY.
- Hit latency: `hit` sampled at edge N gives updated `life` and `invuln` visible after edge N (1 cycle).
- `game_over`/`winner` latency:
  - They assert one cycle after the player's state becomes DEAD, i.e. 2 cycles after the fatal hit.
  - A hit to the surviving player in that intermediate cycle is still applied.
  - If that hit is fatal, `winner` = 11.
- `restart` latency: all outputs take their restart values 1 cycle after the pulse.
- Invulnerability duration:
  - A hit in frame F gives `invuln` = 1 until the INVULN_FRAMES-th following `frame_tick`.
  - At the cycle after that tick, `invuln` = 0 and a new hit is accepted.
- `reset` mid-operation: all outputs return to their reset values immediately (asynchronously), regardless of state.

## Configuration
- Macro `LIFE_REGEN_EN`.
- Defined:
  - Each player in ALIVE with life < LIFE_MAX counts frames.
  - Every REGEN_PERIOD `frame_tick`s, life increases by 1, saturating at LIFE_MAX.
  - The regeneration counter clears on an accepted hit, on entering ALIVE from INVULN, on `restart`, and on `reset`.
  - There is no regeneration in INVULN, DEAD or OVER.
- Undefined: no regeneration logic is synthesized; life never increases except via `restart` or `reset`.

## Test plan
- Reset release, then `hit1` for 1 cycle → `life1` = 75 and `invuln1` = 1 the next cycle; `life2` stays 100.
- `hit1` held high for 59 `frame_tick`s → `life1` stays 75. After the 60th tick, a further `hit1` → `life1` = 50.
- Four spaced `hit2` pulses (each after invulnerability expires):
  - `life2` goes 75, 50, 25, 0.
  - The player-2 FSM enters DEAD; `game_over` = 1 and `winner` = 01 two cycles after the 4th hit.
- Both players at 25, with `hit1` and `hit2` in the same cycle → both lives 0 and `winner` = 11. A subsequent `restart` → both lives 100, `game_over` = 0, `winner` = 00.
- `reset` asserted while `invuln1` = 1 and `life1` = 50 → immediately `life1` = 100 and `invuln1` = 0.
- With `LIFE_REGEN_EN` defined and `life1` = 75 in ALIVE → after 120 `frame_tick`s `life1` = 76. Without the macro → `life1` stays 75.

Source files
------------

// File: rtl/life_if.sv
// Signal bundle between the arena game logic and the per-player health manager.
// master: drives frame/round/hit events and reads health state (game logic or bench).
// slave: receives events and drives health, invulnerability and end-of-round outputs.
interface life_if;
    logic       frame_tick;
    logic       restart;
    logic       hit1;
    logic       hit2;
    logic [6:0] life1;
    logic [6:0] life2;
    logic       invuln1;
    logic       invuln2;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output frame_tick, restart, hit1, hit2,
        input  life1, life2, invuln1, invuln2, game_over, winner
    );

    modport slave (
        input  frame_tick, restart, hit1, hit2,
        output life1, life2, invuln1, invuln2, game_over, winner
    );
endinterface

// File: rtl/life_counter.sv
// Two-player health manager: damage, frame-counted invulnerability, death and winner detection.
// Latency: hit -> life/invuln 1 cycle; fatal hit -> game_over/winner 2 cycles; restart 1 cycle.
// No backpressure: every input is sampled each cycle; optional regeneration under LIFE_REGEN_EN.
module life_counter #(
    parameter int LIFE_MAX      = 100,
    parameter int DAMAGE        = 25,
    parameter int INVULN_FRAMES = 60,
    parameter int REGEN_PERIOD  = 120
) (
    input  logic   clk,
    input  logic   reset,
    life_if.slave  bus
);
    localparam int CW = $clog2(INVULN_FRAMES + 1);

    // Reject parameter sets the 7-bit life path and counters cannot represent.
    if (LIFE_MAX < 1 || LIFE_MAX > 127 || DAMAGE < 1 || DAMAGE > LIFE_MAX ||
        INVULN_FRAMES < 1 || REGEN_PERIOD < 1) begin : g_param_check
        $error("life_counter: illegal parameter combination");
    end

    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} pstate_t;
    typedef enum logic       {PLAY, OVER}           rstate_t;

    pstate_t [1:0]          pst_q;
    logic    [1:0][6:0]     life_q;
    logic    [1:0][CW-1:0]  cnt_q;
    rstate_t                round_q;
    logic                   game_over_q;
    logic    [1:0]          winner_q;

`ifdef LIFE_REGEN_EN
    localparam int RW = $clog2(REGEN_PERIOD + 1);
    logic    [1:0][RW-1:0]  regen_q;
`endif

    logic [1:0]       hit_w;
    logic [1:0][7:0]  diff_w;
    logic [1:0][6:0]  after_hit_w;
    logic [1:0]       fatal_w;

    assign hit_w = {bus.hit2, bus.hit1};

    // Saturating damage and "this cycle's accepted hit kills" per player.
    always_comb begin
        diff_w      = '0;
        after_hit_w = '0;
        fatal_w     = '0;
        for (int p = 0; p < 2; p++) begin
            diff_w[p]      = {1'b0, life_q[p]} - 8'(DAMAGE);
            after_hit_w[p] = diff_w[p][7] ? 7'd0 : diff_w[p][6:0];
            fatal_w[p]     = (round_q == PLAY) && (pst_q[p] == ALIVE) && hit_w[p] &&
                             (after_hit_w[p] == 7'd0);
        end
    end

    // Per-player ALIVE/INVULN/DEAD FSMs; restart overrides everything, hits freeze in OVER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                pst_q[p]   <= ALIVE;
                life_q[p]  <= 7'(LIFE_MAX);
                cnt_q[p]   <= '0;
`ifdef LIFE_REGEN_EN
                regen_q[p] <= '0;
`endif
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (bus.restart) begin
                    pst_q[p]   <= ALIVE;
                    life_q[p]  <= 7'(LIFE_MAX);
                    cnt_q[p]   <= '0;
`ifdef LIFE_REGEN_EN
                    regen_q[p] <= '0;
`endif
                end else begin
                    case (pst_q[p])
                        ALIVE: begin
                            if (round_q == PLAY && hit_w[p]) begin
                                life_q[p] <= after_hit_w[p];
`ifdef LIFE_REGEN_EN
                                regen_q[p] <= '0;
`endif
                                if (after_hit_w[p] == 7'd0) begin
                                    pst_q[p] <= DEAD;
                                end else begin
                                    pst_q[p] <= INVULN;
                                    cnt_q[p] <= CW'(INVULN_FRAMES);
                                end
                            end
`ifdef LIFE_REGEN_EN
                            else if (round_q == PLAY && life_q[p] < 7'(LIFE_MAX)) begin
                                if (bus.frame_tick) begin
                                    if (regen_q[p] == RW'(REGEN_PERIOD - 1)) begin
                                        regen_q[p] <= '0;
                                        life_q[p]  <= life_q[p] + 7'd1;
                                    end else begin
                                        regen_q[p] <= regen_q[p] + RW'(1);
                                    end
                                end
                            end else begin
                                regen_q[p] <= '0;
                            end
`endif
                        end
                        INVULN: begin
                            if (bus.frame_tick) begin
                                if (cnt_q[p] == CW'(1)) begin
                                    pst_q[p] <= ALIVE;
                                    cnt_q[p] <= '0;
`ifdef LIFE_REGEN_EN
                                    regen_q[p] <= '0;
`endif
                                end else begin
                                    cnt_q[p] <= cnt_q[p] - CW'(1);
                                end
                            end
                        end
                        default: begin
                            pst_q[p]  <= DEAD;
                            life_q[p] <= 7'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Round FSM: a registered DEAD moves to OVER; the winner also counts a same-edge fatal hit
    // on the other player, which makes that late kill a draw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_q     <= PLAY;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
        end else if (bus.restart) begin
            round_q     <= PLAY;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
        end else if (round_q == PLAY && (pst_q[0] == DEAD || pst_q[1] == DEAD)) begin
            round_q     <= OVER;
            game_over_q <= 1'b1;
            if (((pst_q[0] == DEAD) || fatal_w[0]) && ((pst_q[1] == DEAD) || fatal_w[1])) begin
                winner_q <= 2'b11;
            end else if (pst_q[1] == DEAD) begin
                winner_q <= 2'b01;
            end else begin
                winner_q <= 2'b10;
            end
        end
    end

    assign bus.life1     = life_q[0];
    assign bus.life2     = life_q[1];
    assign bus.invuln1   = (pst_q[0] == INVULN);
    assign bus.invuln2   = (pst_q[1] == INVULN);
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_life_counter.sv
// Directed bench for life_counter with default parameters (100 / 25 / 60 / 120).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Regeneration expectations follow LIFE_REGEN_EN as seen by this file.
module tb_life_counter;
    logic clk = 1'b0;
    logic reset;
    life_if bus ();

    always #5 clk = ~clk;

    life_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        cycle();
        bus.frame_tick = 1'b0;
        cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic hit_pulse(input logic h1, input logic h2);
        bus.hit1 = h1;
        bus.hit2 = h2;
        cycle();
        bus.hit1 = 1'b0;
        bus.hit2 = 1'b0;
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
    endtask

    int exp_regen;

    initial begin
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b0;
        bus.hit1       = 1'b0;
        bus.hit2       = 1'b0;
        repeat (3) cycle();
        chk("rst_life1", bus.life1, 100);
        chk("rst_life2", bus.life2, 100);
        chk("rst_inv1", bus.invuln1, 0);
        chk("rst_inv2", bus.invuln2, 0);
        chk("rst_go", bus.game_over, 0);
        chk("rst_win", bus.winner, 0);
        reset = 1'b0;
        cycle();

        // single hit on player 1
        hit_pulse(1'b1, 1'b0);
        chk("hit1_life1", bus.life1, 75);
        chk("hit1_inv1", bus.invuln1, 1);
        chk("hit1_life2", bus.life2, 100);

        // hit held through 59 frames is ignored; the frame-60 edge ends invulnerability
        bus.hit1 = 1'b1;
        ticks(59);
        chk("inv_hold_life1", bus.life1, 75);
        chk("inv_hold_inv1", bus.invuln1, 1);
        bus.frame_tick = 1'b1;
        cycle();
        bus.frame_tick = 1'b0;
        chk("inv_end_inv1", bus.invuln1, 0);
        chk("inv_end_life1", bus.life1, 75);
        cycle();
        bus.hit1 = 1'b0;
        chk("rehit_life1", bus.life1, 50);
        chk("rehit_inv1", bus.invuln1, 1);

        // asynchronous reset in the middle of invulnerability
        reset = 1'b1;
        #1;
        chk("async_life1", bus.life1, 100);
        chk("async_inv1", bus.invuln1, 0);
        cycle();
        reset = 1'b0;
        cycle();

        // player 2 killed by four spaced hits
        for (int k = 0; k < 4; k++) begin
            hit_pulse(1'b0, 1'b1);
            chk("p2_life2", bus.life2, 75 - 25 * k);
            if (k < 3) begin
                ticks(60);
                chk("p2_inv2_exp", bus.invuln2, 0);
            end
        end
        chk("p2_go_early", bus.game_over, 0);
        cycle();
        chk("p2_go", bus.game_over, 1);
        chk("p2_win", bus.winner, 1);
        hit_pulse(1'b1, 1'b0);
        chk("over_frozen_life1", bus.life1, 100);
        do_restart();
        chk("rs1_life1", bus.life1, 100);
        chk("rs1_life2", bus.life2, 100);
        chk("rs1_go", bus.game_over, 0);
        chk("rs1_win", bus.winner, 0);

        // simultaneous fatal hits -> draw
        for (int k = 0; k < 3; k++) begin
            hit_pulse(1'b1, 1'b1);
            chk("both_life1", bus.life1, 75 - 25 * k);
            chk("both_life2", bus.life2, 75 - 25 * k);
            ticks(60);
        end
        hit_pulse(1'b1, 1'b1);
        chk("draw_life1", bus.life1, 0);
        chk("draw_life2", bus.life2, 0);
        cycle();
        chk("draw_go", bus.game_over, 1);
        chk("draw_win", bus.winner, 3);
        do_restart();
        chk("rs2_life1", bus.life1, 100);
        chk("rs2_life2", bus.life2, 100);
        chk("rs2_go", bus.game_over, 0);
        chk("rs2_win", bus.winner, 0);

        // fatal hit on the survivor in the cycle between death and game_over -> draw
        for (int k = 0; k < 3; k++) begin
            hit_pulse(1'b1, 1'b1);
            ticks(60);
        end
        hit_pulse(1'b0, 1'b1);
        chk("late_life2", bus.life2, 0);
        chk("late_go_early", bus.game_over, 0);
        hit_pulse(1'b1, 1'b0);
        chk("late_life1", bus.life1, 0);
        chk("late_go", bus.game_over, 1);
        chk("late_win", bus.winner, 3);
        do_restart();

        // regeneration (or its absence) after invulnerability ends at 75
`ifdef LIFE_REGEN_EN
        exp_regen = 76;
`else
        exp_regen = 75;
`endif
        hit_pulse(1'b1, 1'b0);
        ticks(60);
        chk("regen_start", bus.life1, 75);
        ticks(119);
        chk("regen_119", bus.life1, 75);
        tick();
        chk("regen_120", bus.life1, exp_regen);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
